// File: rtl/spi_slave_16.sv
// Clock-oversampled SPI mode-0 slave for DATA_W-bit frames, MSB first.
// Pins are synchronised into clk; a one-deep holding register feeds MISO.
module spi_slave_16 #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_bar,
  input  logic              din_mosi,
  output logic              dout_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [DATA_W-1:0] tx_shift, rx_shift, hold_data;
  logic              hold_full;
  logic [CNT_W-1:0]  bit_cnt;
  logic              reload_armed;

  logic start, stop, sample, fall, transfer, underrun, word_done, load_ok;

  // The cs_bar chain resets to 0 ("selected") so a cs_bar still low at reset
  // release never looks like a falling edge; a fresh high-then-low is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments so every flop
      // samples pre-edge values, making the chain shift rather than collapse.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], din_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // A cs_bar edge swallows any sclk edge seen on the same cycle.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_n = state;
    start   = 1'b0;
    stop    = 1'b0;
    sample  = 1'b0;
    fall    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n = IDLE;
          stop    = 1'b1;
        end else if (!cs_fall) begin
          sample = sclk_rise;
          fall   = sclk_fall;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign transfer  = start | (fall & reload_armed);
  assign underrun  = transfer & ~hold_full;
  assign word_done = sample && (bit_cnt == CNT_W'(DATA_W - 1));
  assign load_ok   = tx_load & ~hold_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data    <= '0;
      hold_full    <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      bit_cnt      <= '0;
      reload_armed <= 1'b0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      tx_underrun  <= 1'b0;
      dout_miso    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= underrun;

      // A load racing an underrun transfer survives for the next frame.
      if (load_ok) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (transfer) begin
        hold_full <= 1'b0;
      end

      if (transfer)  tx_shift <= hold_full ? hold_data : '0;
      else if (fall) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      if (start) begin
        bit_cnt      <= '0;
        reload_armed <= 1'b0;
      end else if (stop) begin
        frame_err    <= (bit_cnt != '0);
        reload_armed <= 1'b0;
      end else if (sample) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        if (word_done) begin
          rx_data      <= {rx_shift[DATA_W-2:0], mosi_s};
          rx_valid     <= 1'b1;
          bit_cnt      <= '0;
          reload_armed <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (fall) begin
        reload_armed <= 1'b0;
      end

      // Forced low on the cycle the frame ends so MISO is 0 for all of IDLE.
      dout_miso <= (state == SHIFT && state_n == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
    end
  end

  assign tx_ready = ~hold_full;
  assign busy     = (state == SHIFT);

endmodule
